pur_sequencer: RTL and testbench



---
 rtl/pur_sequencer.sv | 154 +++++++++++++++
 tb/tb_pur_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pur_sequencer.sv
// pur_sequencer: power-up reset sequencer.
// Holds NUM_CH downstream reset domains in reset for RST_PULSE cycles, then
// releases them one at a time in index order. Each release waits for that
// channel's READY acknowledge, bounded by TIMEOUT. Once every channel is up,
// DONE is held until any READY drops (lost-lock), which raises FAULT.
module pur_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int RST_PULSE = 16,
    parameter int STAGE_DLY = 8,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              SOFT_RST,
    input  logic              REARM,
    input  logic [NUM_CH-1:0] READY,
    output logic [NUM_CH-1:0] RST_OUT_N,
    output logic [3:0]        CH_IDX,
    output logic              DONE,
    output logic              FAULT
);

    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_STAGE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Terminal counts; every state leaves on its last count, so the counter never wraps.
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       LAST_CH    = 4'(NUM_CH - 1);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [3:0]         ch_idx_r;
    logic [NUM_CH-1:0]  rst_out_n_r;
    logic               done_r;
    logic               fault_r;

    logic [NUM_CH-1:0]  ch_mask_s;
    logic               ready_sel_s;

    // Decode the active channel into a one-hot mask and pick its READY bit.
    always_comb begin
        ch_mask_s   = {NUM_CH{1'b0}};
        ready_sel_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_mask_s[i] = (4'(i) == ch_idx_r);
            ready_sel_s  = (4'(i) == ch_idx_r) ? READY[i] : ready_sel_s;
        end
    end

    // Sequencer FSM: reset and soft reset first, then per-state progression.
    always_ff @(posedge CLK) begin
        if (!RSTN || SOFT_RST) begin
            // Hard reset and soft re-sequence land in the same restart state.
            state_r     <= ST_HOLD;
            cnt_r       <= {CNT_W{1'b0}};
            ch_idx_r    <= 4'd0;
            rst_out_n_r <= {NUM_CH{1'b0}};
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_r <= ST_STAGE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_STAGE: begin
                    if (cnt_r == STAGE_LAST) begin
                        rst_out_n_r <= rst_out_n_r | ch_mask_s;
                        state_r     <= ST_WAIT;
                        cnt_r       <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_WAIT: begin
                    // READY on the timeout cycle still counts as success.
                    if (ready_sel_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (ch_idx_r == LAST_CH) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            ch_idx_r <= ch_idx_r + 4'd1;
                            state_r  <= ST_STAGE;
                        end
                    end else if (cnt_r == WAIT_LAST) begin
                        state_r     <= ST_FAULT;
                        rst_out_n_r <= {NUM_CH{1'b0}};
                        done_r      <= 1'b0;
                        fault_r     <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (REARM) begin
                        state_r     <= ST_HOLD;
                        cnt_r       <= {CNT_W{1'b0}};
                        ch_idx_r    <= 4'd0;
                        rst_out_n_r <= {NUM_CH{1'b0}};
                        done_r      <= 1'b0;
                        fault_r     <= 1'b0;
                    end else if (!(&READY)) begin
                        // Lost-lock: CH_IDX already points at the last channel.
                        state_r     <= ST_FAULT;
                        rst_out_n_r <= {NUM_CH{1'b0}};
                        done_r      <= 1'b0;
                        fault_r     <= 1'b1;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                ST_FAULT: begin
                    if (REARM) begin
                        state_r     <= ST_HOLD;
                        cnt_r       <= {CNT_W{1'b0}};
                        ch_idx_r    <= 4'd0;
                        rst_out_n_r <= {NUM_CH{1'b0}};
                        done_r      <= 1'b0;
                        fault_r     <= 1'b0;
                    end else begin
                        state_r <= ST_FAULT;
                    end
                end
                default: begin
                    state_r     <= ST_HOLD;
                    cnt_r       <= {CNT_W{1'b0}};
                    ch_idx_r    <= 4'd0;
                    rst_out_n_r <= {NUM_CH{1'b0}};
                    done_r      <= 1'b0;
                    fault_r     <= 1'b0;
                end
            endcase
        end
    end

    assign RST_OUT_N = rst_out_n_r;
    assign CH_IDX    = ch_idx_r;
    assign DONE      = done_r;
    assign FAULT     = fault_r;

endmodule

// File: tb/tb_pur_sequencer.sv
// Directed bench for pur_sequencer: nominal sequence table plus hand-written
// timeout, lost-lock, soft reset, reset priority and minimal-parameter cases.
module tb_pur_sequencer;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       SOFT_RST = 1'b0;
    logic       REARM = 1'b0;
    logic [3:0] READY = 4'hF;
    logic [3:0] RST_OUT_N;
    logic [3:0] CH_IDX;
    logic       DONE;
    logic       FAULT;

    logic       rstn2 = 1'b0;
    logic       ready2 = 1'b0;
    logic       rst_out_n2;
    logic [3:0] ch_idx2;
    logic       done2;
    logic       fault2;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    typedef struct {
        int         at;
        logic [3:0] rst;
        logic       done;
        logic       fault;
        logic [3:0] ch;
    } vec_t;

    vec_t tbl[13];

    pur_sequencer u_dut (
        .CLK(CLK), .RSTN(RSTN), .SOFT_RST(SOFT_RST), .REARM(REARM),
        .READY(READY), .RST_OUT_N(RST_OUT_N), .CH_IDX(CH_IDX),
        .DONE(DONE), .FAULT(FAULT)
    );

    pur_sequencer #(.NUM_CH(1), .RST_PULSE(1), .STAGE_DLY(1), .TIMEOUT(1), .CNT_W(4)) u_small (
        .CLK(CLK), .RSTN(rstn2), .SOFT_RST(1'b0), .REARM(1'b0),
        .READY(ready2), .RST_OUT_N(rst_out_n2), .CH_IDX(ch_idx2),
        .DONE(done2), .FAULT(fault2)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] rst, input logic done,
                             input logic fault, input logic [3:0] ch);
        check({tag, ".rst_out_n"}, RST_OUT_N, rst);
        check({tag, ".done"}, DONE, done);
        check({tag, ".fault"}, FAULT, fault);
        check({tag, ".ch_idx"}, CH_IDX, ch);
    endtask

    // Nominal sequence; edge_n must be 0 at the restart edge.
    task automatic run_table(input string tag);
        for (int i = 0; i < 13; i++) begin
            while (edge_n < tbl[i].at) tick();
            check_all(tag, tbl[i].rst, tbl[i].done, tbl[i].fault, tbl[i].ch);
        end
    endtask

    initial begin
        tbl[0]  = '{0,  4'b0000, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{23, 4'b0000, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{24, 4'b0001, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{25, 4'b0001, 1'b0, 1'b0, 4'd1};
        tbl[4]  = '{32, 4'b0001, 1'b0, 1'b0, 4'd1};
        tbl[5]  = '{33, 4'b0011, 1'b0, 1'b0, 4'd1};
        tbl[6]  = '{41, 4'b0011, 1'b0, 1'b0, 4'd2};
        tbl[7]  = '{42, 4'b0111, 1'b0, 1'b0, 4'd2};
        tbl[8]  = '{50, 4'b0111, 1'b0, 1'b0, 4'd3};
        tbl[9]  = '{51, 4'b1111, 1'b0, 1'b0, 4'd3};
        tbl[10] = '{52, 4'b1111, 1'b1, 1'b0, 4'd3};
        tbl[11] = '{53, 4'b1111, 1'b1, 1'b0, 4'd3};
        tbl[12] = '{60, 4'b1111, 1'b1, 1'b0, 4'd3};

        // Nominal power-up with all READY high.
        repeat (3) tick();
        RSTN = 1'b1;
        edge_n = 0;
        check_all("reset", 4'b0000, 1'b0, 1'b0, 4'd0);
        run_table("nominal");

        // Timeout on channel 2.
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        READY = 4'b1011;
        edge_n = 0;
        while (edge_n < 42) tick();
        check_all("to_rel2", 4'b0111, 1'b0, 1'b0, 4'd2);
        while (edge_n < 1065) tick();
        check_all("to_pre", 4'b0111, 1'b0, 1'b0, 4'd2);
        tick();
        check_all("to_fault", 4'b0000, 1'b0, 1'b1, 4'd2);
        tick();
        check_all("to_sticky", 4'b0000, 1'b0, 1'b1, 4'd2);
        READY = 4'hF;
        REARM = 1'b1;
        tick();
        REARM = 1'b0;
        edge_n = 0;
        run_table("rearm");

        // Lost-lock from DONE: READY[1] drops for one cycle.
        READY = 4'b1101;
        tick();
        READY = 4'hF;
        check_all("lost", 4'b0000, 1'b0, 1'b1, 4'd3);
        tick();
        check_all("lost_sticky", 4'b0000, 1'b0, 1'b1, 4'd3);

        // Rearm with ch1 stuck, REARM ignored while waiting, then SOFT_RST.
        READY = 4'b1101;
        REARM = 1'b1;
        tick();
        REARM = 1'b0;
        edge_n = 0;
        while (edge_n < 33) tick();
        check_all("w1_rel", 4'b0011, 1'b0, 1'b0, 4'd1);
        while (edge_n < 35) tick();
        REARM = 1'b1;
        tick();
        REARM = 1'b0;
        check_all("w1_rearm_ign", 4'b0011, 1'b0, 1'b0, 4'd1);
        while (edge_n < 40) tick();
        SOFT_RST = 1'b1;
        tick();
        SOFT_RST = 1'b0;
        edge_n = 0;
        check_all("soft", 4'b0000, 1'b0, 1'b0, 4'd0);
        while (edge_n < 23) tick();
        check_all("soft_23", 4'b0000, 1'b0, 1'b0, 4'd0);
        tick();
        check_all("soft_24", 4'b0001, 1'b0, 1'b0, 4'd0);

        // RSTN mid-STAGE of ch1 together with SOFT_RST and REARM.
        while (edge_n < 28) tick();
        RSTN = 1'b0;
        SOFT_RST = 1'b1;
        REARM = 1'b1;
        tick();
        check_all("rst_prio", 4'b0000, 1'b0, 1'b0, 4'd0);
        RSTN = 1'b1;
        SOFT_RST = 1'b0;
        REARM = 1'b0;
        READY = 4'hF;
        edge_n = 0;
        run_table("after_rst");

        // SOFT_RST held high pins the block in HOLD.
        SOFT_RST = 1'b1;
        repeat (30) tick();
        check_all("soft_held", 4'b0000, 1'b0, 1'b0, 4'd0);
        SOFT_RST = 1'b0;
        edge_n = 0;
        run_table("soft_release");

        // Minimal parameters: single channel, all counts of one.
        ready2 = 1'b0;
        rstn2 = 1'b1;
        edge_n = 0;
        tick();
        check("small.rel1", rst_out_n2, 1'b0);
        tick();
        check("small.rel2", rst_out_n2, 1'b1);
        check("small.nofault2", fault2, 1'b0);
        tick();
        check("small.fault3", fault2, 1'b1);
        check("small.rst3", rst_out_n2, 1'b0);
        check("small.ch3", ch_idx2, 4'd0);
        rstn2 = 1'b0;
        tick();
        rstn2 = 1'b1;
        ready2 = 1'b1;
        edge_n = 0;
        tick();
        tick();
        check("small.rel2b", rst_out_n2, 1'b1);
        check("small.done2", done2, 1'b0);
        tick();
        check("small.done3", done2, 1'b1);
        check("small.fault_ok", fault2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
